// File: rtl/operand_loader.sv
// Serial-to-parallel operand collector: gathers 16 bytes over valid/ready and
// presents them in parallel, held stable until the downstream stage releases.
module operand_loader #(
  parameter int DATAWIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATAWIDTH-1:0] in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 flush,
  output logic [DATAWIDTH-1:0] a,
  output logic [DATAWIDTH-1:0] b,
  output logic [DATAWIDTH-1:0] c,
  output logic [DATAWIDTH-1:0] d,
  output logic [DATAWIDTH-1:0] e,
  output logic [DATAWIDTH-1:0] f,
  output logic [DATAWIDTH-1:0] g,
  output logic [DATAWIDTH-1:0] h,
  output logic [DATAWIDTH-1:0] i,
  output logic [DATAWIDTH-1:0] j,
  output logic [DATAWIDTH-1:0] k,
  output logic [DATAWIDTH-1:0] l,
  output logic [DATAWIDTH-1:0] m,
  output logic [DATAWIDTH-1:0] n,
  output logic [DATAWIDTH-1:0] o,
  output logic [DATAWIDTH-1:0] p,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [4:0]           fill_level
);

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t               state_r;
  logic [3:0]           idx_r;
  logic [4:0]           fill_level_r;
  logic                 out_valid_r;
  logic [DATAWIDTH-1:0] slots_r [16];
  logic                 accept_s;

  // Ready drops the instant flush or reset is seen so a coincident byte is never taken
  assign in_ready = (state_r == FILL) && !flush && !rst;
  assign accept_s = in_ready && in_valid;

  // Frame sequencing: fill slots in order, hold the full frame until released
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= FILL;
      idx_r        <= 4'd0;
      fill_level_r <= 5'd0;
      out_valid_r  <= 1'b0;
      for (int s = 0; s < 16; s++) begin
        slots_r[s] <= '0;
      end
    end else if (flush) begin
      state_r      <= FILL;
      idx_r        <= 4'd0;
      fill_level_r <= 5'd0;
      out_valid_r  <= 1'b0;
    end else begin
      case (state_r)
        FILL: begin
          if (accept_s) begin
            slots_r[idx_r] <= in_data;
            idx_r          <= idx_r + 4'd1;
            fill_level_r   <= fill_level_r + 5'd1;
            if (idx_r == 4'd15) begin
              state_r     <= HOLD;
              out_valid_r <= 1'b1;
            end else begin
              state_r     <= FILL;
              out_valid_r <= 1'b0;
            end
          end else begin
            state_r <= FILL;
          end
        end
        HOLD: begin
          if (out_ready) begin
            state_r      <= FILL;
            idx_r        <= 4'd0;
            fill_level_r <= 5'd0;
            out_valid_r  <= 1'b0;
          end else begin
            state_r <= HOLD;
          end
        end
        default: begin
          state_r      <= FILL;
          idx_r        <= 4'd0;
          fill_level_r <= 5'd0;
          out_valid_r  <= 1'b0;
        end
      endcase
    end
  end

  assign out_valid  = out_valid_r;
  assign fill_level = fill_level_r;

  // Slot values drive the outputs straight from flops so downstream sees no glitches
  assign a = slots_r[0];
  assign b = slots_r[1];
  assign c = slots_r[2];
  assign d = slots_r[3];
  assign e = slots_r[4];
  assign f = slots_r[5];
  assign g = slots_r[6];
  assign h = slots_r[7];
  assign i = slots_r[8];
  assign j = slots_r[9];
  assign k = slots_r[10];
  assign l = slots_r[11];
  assign m = slots_r[12];
  assign n = slots_r[13];
  assign o = slots_r[14];
  assign p = slots_r[15];

endmodule

// File: tb/tb_operand_loader.sv
// Scoreboard bench for operand_loader: complete frames are queued as they are
// driven and compared when out_valid rises, together with a downstream sum.
module tb_operand_loader;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] in_data = 8'd0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic       flush = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [4:0] fill_level;
  logic [7:0] sa, sb_, sc, sd, se, sf, sg, sh, si, sj, sk, sl, sm, sn, so, sp;

  always #5 clk = ~clk;

  operand_loader #(.DATAWIDTH(8)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .flush(flush),
    .a(sa), .b(sb_), .c(sc), .d(sd), .e(se), .f(sf), .g(sg), .h(sh),
    .i(si), .j(sj), .k(sk), .l(sl), .m(sm), .n(sn), .o(so), .p(sp),
    .out_valid(out_valid), .out_ready(out_ready), .fill_level(fill_level)
  );

  logic [127:0] dut_vec;
  assign dut_vec = {sp, so, sn, sm, sl, sk, sj, si, sh, sg, sf, se, sd, sc, sb_, sa};

  int           checks = 0;
  int           errors = 0;
  int           cyc = 0;
  logic [127:0] sb_q [$];
  logic [127:0] cur_frame = '0;
  int           cur_cnt = 0;
  logic         prev_ov = 1'b0;
  logic         sum_pending = 1'b0;
  logic [31:0]  exp_sum = 32'd0;
  logic [127:0] held = '0;
  logic [127:0] popped;
  int           rise_cyc = 0;
  int           n_rise = 0;
  int           t0 = 0;
  int           r1 = 0;
  logic [31:0]  final_sum_r = 32'd0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] frame_sum(input logic [127:0] fr);
    logic [31:0] s;
    s = 32'd0;
    for (int q = 0; q < 16; q++) s = s + 32'(fr[8*q +: 8]);
    return s;
  endfunction

  // Downstream accumulate register
  always @(posedge clk) final_sum_r <= frame_sum(dut_vec);

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor: pop the scoreboard on each out_valid rise
  always @(negedge clk) begin
    if (sum_pending) begin
      check("final_sum", 128'(final_sum_r), 128'(exp_sum));
      sum_pending = 1'b0;
    end
    if (out_valid && prev_ov) check("hold_stable", dut_vec, held);
    if (out_valid && !prev_ov) begin
      rise_cyc = cyc;
      n_rise++;
      check("sb_nonempty", 128'(sb_q.size() > 0), 128'(1));
      if (sb_q.size() > 0) begin
        popped = sb_q.pop_front();
        held = popped;
        check("slots", dut_vec, popped);
        check("full_level", 128'(fill_level), 128'(16));
        check("full_ready", 128'(in_ready), 128'(0));
        exp_sum = frame_sum(popped);
        sum_pending = 1'b1;
      end
    end
    prev_ov = out_valid;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] bval);
    in_data = bval;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    cur_frame[8*cur_cnt +: 8] = bval;
    cur_cnt++;
    if (cur_cnt == 16) begin
      sb_q.push_back(cur_frame);
      cur_cnt = 0;
    end
  endtask

  task automatic release_frame();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_slots"}, dut_vec, 128'(0));
    check({tag, "_fill"}, 128'(fill_level), 128'(0));
    check({tag, "_ovalid"}, 128'(out_valid), 128'(0));
    check({tag, "_iready"}, 128'(in_ready), 128'(0));
  endtask

  initial begin
    #2;
    check_reset_values("rst0");
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rel_ready", 128'(in_ready), 128'(1));

    // Contiguous frame 0x01..0x10
    t0 = cyc;
    for (int q = 0; q < 16; q++) send(8'(q + 1));
    @(negedge clk);
    #1;
    check("lat16", 128'(rise_cyc - t0), 128'(16));

    // HOLD ignores input bytes
    in_data = 8'hFF;
    in_valid = 1'b1;
    repeat (5) tick();
    check("hold_fill", 128'(fill_level), 128'(16));
    check("hold_ov", 128'(out_valid), 128'(1));
    check("hold_a", 128'(sa), 128'(8'h01));
    check("hold_p", 128'(sp), 128'(8'h10));
    in_valid = 1'b0;
    release_frame();
    check("rel_ov", 128'(out_valid), 128'(0));
    check("rel_fill", 128'(fill_level), 128'(0));
    check("rel_iready", 128'(in_ready), 128'(1));
    check("rel_a_kept", 128'(sa), 128'(8'h01));

    // Bubbly input
    t0 = cyc;
    for (int q = 0; q < 16; q++) begin
      send(8'hFF);
      if (q < 15) tick();
    end
    @(negedge clk);
    #1;
    check("lat31", 128'(rise_cyc - t0), 128'(31));
    release_frame();

    // Flush after 7 bytes, coincident byte dropped
    for (int q = 0; q < 7; q++) send(8'(8'h21 + q));
    check("part_fill", 128'(fill_level), 128'(7));
    in_data = 8'hAA;
    in_valid = 1'b1;
    flush = 1'b1;
    #1;
    check("flush_ready", 128'(in_ready), 128'(0));
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    cur_cnt = 0;
    check("flush_fill", 128'(fill_level), 128'(0));
    check("flush_ov", 128'(out_valid), 128'(0));
    check("flush_h", 128'(sh), 128'(8'hFF));
    check("flush_a", 128'(sa), 128'(8'h21));
    for (int q = 0; q < 16; q++) send(8'(8'h31 + q));
    @(negedge clk);
    #1;
    check("newframe_a", 128'(sa), 128'(8'h31));
    release_frame();

    // Reset mid-frame
    for (int q = 0; q < 9; q++) send(8'(8'h51 + q));
    rst = 1'b1;
    #1;
    check_reset_values("rstmid");
    rst = 1'b0;
    cur_cnt = 0;
    #1;
    check("rstmid_rel", 128'(in_ready), 128'(1));

    // Reset in HOLD
    for (int q = 0; q < 16; q++) send(8'(8'h61 + q));
    repeat (3) tick();
    check("prehold_ov", 128'(out_valid), 128'(1));
    rst = 1'b1;
    #1;
    check_reset_values("rsthold");
    rst = 1'b0;
    #1;
    check("rsthold_rel", 128'(in_ready), 128'(1));

    // Back-to-back frames with out_ready tied high
    out_ready = 1'b1;
    for (int q = 0; q < 16; q++) send(8'(8'h81 + q));
    in_data = 8'hEE;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    r1 = rise_cyc;
    for (int q = 0; q < 16; q++) send(8'(8'hC1 + q));
    @(negedge clk);
    #1;
    check("b2b_gap", 128'(rise_cyc - r1), 128'(17));
    out_ready = 1'b0;
    repeat (3) tick();

    check("sb_drained", 128'(sb_q.size()), 128'(0));
    check("frame_count", 128'(n_rise), 128'(6));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
